freq_counter_mc: RTL and testbench

Multi-channel, parametrised frequency meter. Each channel counts rising edges of an asynchronous input over a shared gate window whose length is selectable at run time. At the end of every window all channel counts are latched together and a one-cycle `valid` strobe is issued. The block sits between external pulse inputs and the display/readout logic. It replaces the single-channel fixed-1 s counter with exact gate lengths, input synchronisation, saturation and a hold mode.

---
 rtl/freq_pkg.sv | 30 +++
 rtl/freq_counter_mc_channel.sv | 62 ++++++
 rtl/freq_counter_mc.sv | 93 +++++++++
 tb/tb_freq_counter_mc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the multi-channel frequency meter: gate encodings,
// gate-length helper and the window-control state type.
package freq_pkg;

    localparam logic [1:0] GATE_1S    = 2'd0;
    localparam logic [1:0] GATE_100MS = 2'd1;
    localparam logic [1:0] GATE_10MS  = 2'd2;
    localparam logic [1:0] GATE_1MS   = 2'd3;

    typedef enum logic {
        RESTART = 1'b0,
        RUN     = 1'b1
    } state_t;

    // Window length in clk cycles for a gate selection.
    function automatic int unsigned gate_cycles(input logic [1:0] sel,
                                                input int unsigned clk_hz);
        int unsigned g;
        g = clk_hz;
        case (sel)
            GATE_1S:    g = clk_hz;
            GATE_100MS: g = clk_hz / 10;
            GATE_10MS:  g = clk_hz / 100;
            GATE_1MS:   g = clk_hz / 1000;
            default:    g = clk_hz;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/freq_counter_mc_channel.sv
// One measurement channel: input synchroniser, rising-edge detector,
// saturating window counter with sticky overflow, and output latch.
module freq_channel #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal,
    input  logic             clear,
    input  logic             latch,
    output logic [CNT_W-1:0] count_value,
    output logic             overflow
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;

    logic                   rise_c;
    logic [CNT_W-1:0]       cnt_next_c;
    logic                   ovf_next_c;

    assign rise_c     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign cnt_next_c = cnt_q + CNT_W'(rise_c & ~(&cnt_q));
    assign ovf_next_c = ovf_q | (&cnt_next_c);

    // Synchroniser chain and previous-value register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Running saturating counter and sticky overflow for the open window.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next_c;
            ovf_q <= ovf_next_c;
        end
    end

    // Reported value includes an edge landing on the window's last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_value <= '0;
            overflow    <= 1'b0;
        end else if (latch) begin
            count_value <= cnt_next_c;
            overflow    <= ovf_next_c;
        end
    end

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel frequency meter: shared gate window timer, gate-change
// restart control, hold/valid handling and per-channel instantiation.
module freq_counter_mc
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       signal,
    input  logic [1:0]                gate_sel,
    input  logic                      hold,
    output logic [CHANNELS*CNT_W-1:0] count_value,
    output logic [CHANNELS-1:0]       overflow,
    output logic                      valid
);

    localparam int unsigned TMR_W = $clog2(CLK_HZ);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       gate_q;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] last_c;
    logic             gate_chg_c;
    logic             restart_c;
    logic             win_end_c;
    logic             clear_c;
    logic             latch_c;

    assign last_c     = TMR_W'(gate_cycles(gate_q, CLK_HZ) - 1);
    assign gate_chg_c = (gate_sel != gate_q);
    assign win_end_c  = (state_q == RUN) && !gate_chg_c && (timer_q == last_c);
    assign clear_c    = restart_c | win_end_c;
    assign latch_c    = win_end_c & ~hold;

    // Window-control state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RESTART;
        else     state_q <= state_d;
    end

    // Next state: a restart lasts one cycle; a gate change aborts a running window.
    always_comb begin
        state_d   = state_q;
        restart_c = 1'b0;
        case (state_q)
            RESTART: begin
                restart_c = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (gate_chg_c) state_d = RESTART;
            end
        endcase
    end

    // Registered gate selection; loaded during reset so release is not seen as a change.
    always_ff @(posedge clk) begin
        gate_q <= gate_sel;
    end

    // Window timer counts 0..G-1 and restarts on window end or abort.
    always_ff @(posedge clk) begin
        if (rst || restart_c || gate_chg_c || win_end_c) timer_q <= '0;
        else                                             timer_q <= timer_q + TMR_W'(1);
    end

    // Completion strobe, suppressed while outputs are held.
    always_ff @(posedge clk) begin
        if (rst) valid <= 1'b0;
        else     valid <= latch_c;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        freq_channel #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .signal     (signal[i]),
            .clear      (clear_c),
            .latch      (latch_c),
            .count_value(count_value[i*CNT_W +: CNT_W]),
            .overflow   (overflow[i])
        );
    end

endmodule

// File: tb/tb_freq_counter_mc.sv
// Self-checking bench for freq_counter_mc with a window-level reference model.
module tb_freq_counter_mc;

    localparam int CLK_HZ = 1000;
    localparam int CH     = 2;
    localparam int CW     = 5;
    localparam int S      = 2;
    localparam int MAXV   = (1 << CW) - 1;
    localparam int MAXC   = 8000;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       signal;
    logic [1:0]          gate_sel;
    logic                hold;
    logic [CH*CW-1:0]    count_value;
    logic [CH-1:0]       overflow;
    logic                valid;

    freq_counter_mc #(
        .CLK_HZ     (CLK_HZ),
        .CHANNELS   (CH),
        .CNT_W      (CW),
        .SYNC_STAGES(S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal     (signal),
        .gate_sel   (gate_sel),
        .hold       (hold),
        .count_value(count_value),
        .overflow   (overflow),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [CH-1:0] hist [0:MAXC-1];

    // Stimulus controls: half>0 toggles every half cycles, 0 drives fixv, <0 random.
    int            half [CH];
    logic [CH-1:0] fixv;
    logic          rst_v;
    logic          hold_v;
    logic [1:0]    gsel_v;

    // Reference model state.
    bit            m_restart;
    logic [1:0]    m_gate;
    int            m_pos;
    int            m_edges [CH];
    int            exp_cnt [CH];
    logic [CH-1:0] exp_ovf;
    logic          exp_valid;

    function automatic int glen(input logic [1:0] g);
        int d = 1;
        for (int i = 0; i < int'(g); i++) d = d * 10;
        return CLK_HZ / d;
    endfunction

    function automatic logic [CH*CW-1:0] exp_vec();
        logic [CH*CW-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i*CW +: CW] = CW'(exp_cnt[i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [CH-1:0] e);
        if (rst_v) begin
            m_restart = 1'b1;
            m_gate    = gsel_v;
            m_pos     = 0;
            for (int i = 0; i < CH; i++) begin m_edges[i] = 0; exp_cnt[i] = 0; end
            exp_ovf   = '0;
            exp_valid = 1'b0;
        end else if (m_restart) begin
            m_restart = 1'b0;
            m_gate    = gsel_v;
            m_pos     = 0;
            for (int i = 0; i < CH; i++) m_edges[i] = 0;
            exp_valid = 1'b0;
        end else if (gsel_v != m_gate) begin
            m_gate    = gsel_v;
            m_restart = 1'b1;
            exp_valid = 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) m_edges[i] += int'(e[i]);
            if (m_pos == glen(m_gate) - 1) begin
                exp_valid = !hold_v;
                if (!hold_v) begin
                    for (int i = 0; i < CH; i++) begin
                        exp_cnt[i] = (m_edges[i] > MAXV) ? MAXV : m_edges[i];
                        exp_ovf[i] = (m_edges[i] >= MAXV);
                    end
                end
                for (int i = 0; i < CH; i++) m_edges[i] = 0;
                m_pos = 0;
            end else begin
                m_pos++;
                exp_valid = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check all outputs.
    task automatic step();
        logic [CH-1:0] s;
        logic [CH-1:0] e;
        for (int i = 0; i < CH; i++) begin
            if (rst_v)            s[i] = 1'b0;
            else if (half[i] == 0) s[i] = fixv[i];
            else if (half[i] < 0)  s[i] = 1'($urandom);
            else                   s[i] = 1'((cyc / half[i]) % 2);
        end
        hist[cyc] = s;
        signal    = s;
        rst       = rst_v;
        hold      = hold_v;
        gate_sel  = gsel_v;
        // A rising input edge is seen by the counter S cycles after it is driven.
        e = (cyc >= S + 1) ? (hist[cyc-S] & ~hist[cyc-S-1]) : '0;
        @(posedge clk);
        model_update(e);
        #1;
        check("valid", 64'(valid), 64'(exp_valid));
        check("count", 64'(count_value), 64'(exp_vec()));
        check("ovf", 64'(overflow), 64'(exp_ovf));
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (valid !== 1'b1 && n < budget);
        n_tests++;
        assert (valid === 1'b1) else begin
            n_fail++;
            $error("FAIL wait_valid observed=%b expected=1 after %0d cycles", valid, n);
        end
    endtask

    initial begin
        int n;
        int pulses;
        half[0] = 0; half[1] = 0; fixv = '0;
        rst_v = 1'b1; hold_v = 1'b0; gsel_v = 2'd3;
        m_restart = 1'b1; m_gate = 2'd3; m_pos = 0; exp_ovf = '0; exp_valid = 1'b0;
        for (int i = 0; i < CH; i++) begin m_edges[i] = 0; exp_cnt[i] = 0; end

        // Reset state.
        repeat (4) step();
        check("rst_count", 64'(count_value), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));

        // Gate 3 (G=1), idle inputs: valid every cycle.
        rst_v = 1'b0;
        repeat (3) step();
        pulses = 0;
        repeat (5) begin step(); if (valid === 1'b1) pulses++; end
        check("g3_pulses", 64'(pulses), 64'(5));

        // Gate 1 (G=100), periodic inputs: steady counts 10 and 25.
        gsel_v = 2'd1; half[0] = 5; half[1] = 2;
        wait_valid(300, n);
        wait_valid(300, n);
        wait_valid(300, n);
        check("g1_period", 64'(n), 64'(100));
        check("g1_ch0", 64'(count_value[0 +: CW]), 64'(10));
        check("g1_ch1", 64'(count_value[CW +: CW]), 64'(25));

        // Gate 2 (G=10): edge detected on the window's last cycle.
        gsel_v = 2'd2; half[0] = 0; half[1] = 0; fixv = '0;
        wait_valid(50, n);
        wait_valid(50, n);
        repeat (7) step();
        fixv[0] = 1'b1;
        wait_valid(20, n);
        check("last_edge_lat", 64'(n), 64'(3));
        check("last_edge_in", 64'(count_value[0 +: CW]), 64'(1));
        wait_valid(20, n);
        check("next_from_zero", 64'(count_value[0 +: CW]), 64'(0));

        // Saturation: ~50 edges into a 5-bit counter.
        gsel_v = 2'd1; half[0] = 1; fixv = '0;
        wait_valid(300, n);
        check("sat_ch0", 64'(count_value[0 +: CW]), 64'(MAXV));
        check("sat_ch1", 64'(count_value[CW +: CW]), 64'(0));
        check("sat_ovf", 64'(overflow), 64'(2'b01));
        half[0] = 0;
        wait_valid(300, n);
        wait_valid(300, n);
        check("quiet_ch0", 64'(count_value[0 +: CW]), 64'(0));
        check("quiet_ovf", 64'(overflow), 64'(0));

        // Gate switch at timer 50 aborts the window.
        repeat (50) step();
        gsel_v = 2'd2;
        step();
        wait_valid(30, n);
        check("switch_latency", 64'(n), 64'(11));

        // Hold across one window end.
        half[0] = -1; half[1] = -1;
        wait_valid(20, n);
        hold_v = 1'b1;
        pulses = 0;
        repeat (10) begin step(); if (valid === 1'b1) pulses++; end
        check("hold_no_valid", 64'(pulses), 64'(0));
        check("hold_count", 64'(count_value), 64'(exp_vec()));
        hold_v = 1'b0;
        wait_valid(20, n);
        check("hold_release", 64'(n), 64'(10));

        // Reset mid-window.
        repeat (4) step();
        rst_v = 1'b1;
        step();
        check("rst_mid_count", 64'(count_value), 64'(0));
        check("rst_mid_ovf", 64'(overflow), 64'(0));
        check("rst_mid_valid", 64'(valid), 64'(0));
        repeat (2) step();
        rst_v = 1'b0;

        // Randomised operation against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) gsel_v = 2'($urandom_range(1, 3));
            hold_v = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) half[1] = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 4));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
